// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - shared opcodes, state/class encodings and control word for the SRC sequencer
package mini_src_pkg;

  localparam int OPC_W   = 5;
  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_LOADI, CLS_STORE, CLS_ALU_R, CLS_ALU_I, CLS_BRANCH, CLS_JR,
    CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } opclass_t;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
    logic outport_in, inport_in, con_in;
    logic gra, grb, grc, r_in, r_out;
    logic inc_pc, read, write;
  } ctrl_t;

  // Final execute step of each class; the instruction boundary is taken there.
  function automatic state_t last_state(opclass_t c);
    case (c)
      CLS_LOAD, CLS_STORE:              return S_T7;
      CLS_BRANCH:                       return S_T6;
      CLS_LOADI, CLS_ALU_R, CLS_ALU_I:  return S_T5;
      default:                          return S_T3;
    endcase
  endfunction

  function automatic state_t next_exec(state_t s);
    case (s)
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_T0;
    endcase
  endfunction

endpackage

// File: rtl/mini_src_opclass_decode.sv
// rtl/mini_src_opclass_decode.sv - combinational opcode to instruction class decode
module mini_src_opclass_decode
  import mini_src_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output opclass_t         o_cls
);

  // Anything not listed, including explicit nop, sequences as a one-step no-op.
  always_comb begin
    o_cls = CLS_NOP;
    case (i_opcode)
      OP_LD:                          o_cls = CLS_LOAD;
      OP_LDI:                         o_cls = CLS_LOADI;
      OP_ST:                          o_cls = CLS_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  o_cls = CLS_ALU_R;
      OP_ADDI:                        o_cls = CLS_ALU_I;
      OP_BR:                          o_cls = CLS_BRANCH;
      OP_JR:                          o_cls = CLS_JR;
      OP_IN:                          o_cls = CLS_IN;
      OP_OUT:                         o_cls = CLS_OUT;
      OP_MFHI:                        o_cls = CLS_MFHI;
      OP_MFLO:                        o_cls = CLS_MFLO;
      OP_HALT:                        o_cls = CLS_HALT;
      default:                        o_cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// rtl/mini_src_control_unit.sv - hardwired Moore sequencer driving every Datapath control input
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int IR_W     = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            run,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            BAout,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            HIin,
  output logic            LOin,
  output logic            OutPortin,
  output logic            InPortin,
  output logic            CONin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            IncPC,
  output logic            Read,
  output logic            Write
);

  state_t                r_state;
  opclass_t              r_cls;
  logic                  r_stop_pend;
  logic [OPCODE_W-1:0]   w_opcode;
  opclass_t              w_cls_live;
  opclass_t              w_cls;
  logic                  w_boundary;
  logic                  w_unused_ir;
  ctrl_t                 w_ctrl;

  assign w_opcode    = ir[IR_W-1 -: OPCODE_W];
  assign w_unused_ir = ^ir[IR_W-OPCODE_W-1:0];

  mini_src_opclass_decode u_decode (
    .i_opcode (w_opcode),
    .o_cls    (w_cls_live)
  );

  // IR is only valid from T3 on, so T3 decodes live and later steps use the latched class.
  assign w_cls      = (r_state == S_T3) ? w_cls_live : r_cls;
  assign w_boundary = (r_state == last_state(w_cls));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= S_RST;
      r_cls       <= CLS_NOP;
      r_stop_pend <= 1'b0;
    end else begin
      unique case (r_state)
        S_RST:  r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_HALT: r_state <= S_HALT;
        default: begin
          if (w_cls == CLS_HALT) begin
            r_state <= S_HALT;
          end else if (w_boundary) begin
            r_state <= (stop || r_stop_pend) ? S_HALT : S_T0;
          end else begin
            r_state <= next_exec(r_state);
          end
        end
      endcase
      if (r_state == S_T3) begin
        r_cls <= w_cls_live;
      end
      // A stop seen anywhere in an instruction is held until its boundary.
      if (r_state == S_HALT || w_boundary) begin
        r_stop_pend <= 1'b0;
      end else begin
        r_stop_pend <= r_stop_pend | stop;
      end
    end
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_T0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1; w_ctrl.inc_pc = 1'b1; w_ctrl.pc_in = 1'b1;
      end
      S_T1: begin
        w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
      end
      S_T3: begin
        case (w_cls)
          CLS_LOAD, CLS_LOADI, CLS_STORE: begin
            w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
          end
          CLS_ALU_R, CLS_ALU_I: begin
            w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1;
          end
          CLS_BRANCH: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.con_in = 1'b1;
          end
          CLS_JR: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1;
          end
          CLS_IN: begin
            w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CLS_OUT: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.outport_in = 1'b1;
          end
          CLS_MFHI: begin
            w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CLS_MFLO: begin
            w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          default: w_ctrl = '0;
        endcase
      end
      S_T4: begin
        case (w_cls)
          CLS_LOAD, CLS_LOADI, CLS_STORE, CLS_ALU_I: begin
            w_ctrl.c_out = 1'b1; w_ctrl.zlow_in = 1'b1;
          end
          CLS_ALU_R: begin
            w_ctrl.grc = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.zlow_in = 1'b1;
          end
          CLS_BRANCH: begin
            w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
          end
          default: w_ctrl = '0;
        endcase
      end
      S_T5: begin
        case (w_cls)
          CLS_LOAD, CLS_STORE: begin
            w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
          end
          CLS_LOADI, CLS_ALU_R, CLS_ALU_I: begin
            w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CLS_BRANCH: begin
            w_ctrl.c_out = 1'b1; w_ctrl.zlow_in = 1'b1;
          end
          default: w_ctrl = '0;
        endcase
      end
      S_T6: begin
        case (w_cls)
          CLS_LOAD: begin
            w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
          end
          CLS_STORE: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.mdr_in = 1'b1;
          end
          CLS_BRANCH: begin
            w_ctrl.zlow_out = con_ff; w_ctrl.pc_in = con_ff;
          end
          default: w_ctrl = '0;
        endcase
      end
      S_T7: begin
        case (w_cls)
          CLS_LOAD: begin
            w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CLS_STORE: w_ctrl.write = 1'b1;
          default:   w_ctrl = '0;
        endcase
      end
      default: w_ctrl = '0;
    endcase
  end

  assign run       = (r_state != S_HALT);
  assign PCout     = w_ctrl.pc_out;
  assign Zhighout  = w_ctrl.zhigh_out;
  assign Zlowout   = w_ctrl.zlow_out;
  assign MDRout    = w_ctrl.mdr_out;
  assign HIout     = w_ctrl.hi_out;
  assign LOout     = w_ctrl.lo_out;
  assign InPortout = w_ctrl.inport_out;
  assign Cout      = w_ctrl.c_out;
  assign BAout     = w_ctrl.ba_out;
  assign PCin      = w_ctrl.pc_in;
  assign IRin      = w_ctrl.ir_in;
  assign MARin     = w_ctrl.mar_in;
  assign MDRin     = w_ctrl.mdr_in;
  assign Yin       = w_ctrl.y_in;
  assign Zlowin    = w_ctrl.zlow_in;
  assign Zhighin   = w_ctrl.zhigh_in;
  assign HIin      = w_ctrl.hi_in;
  assign LOin      = w_ctrl.lo_in;
  assign OutPortin = w_ctrl.outport_in;
  assign InPortin  = w_ctrl.inport_in;
  assign CONin     = w_ctrl.con_in;
  assign Gra       = w_ctrl.gra;
  assign Grb       = w_ctrl.grb;
  assign Grc       = w_ctrl.grc;
  assign Rin       = w_ctrl.r_in;
  assign Rout      = w_ctrl.r_out;
  assign IncPC     = w_ctrl.inc_pc;
  assign Read      = w_ctrl.read;
  assign Write     = w_ctrl.write;

endmodule
